// File: rtl/aes_dec_sched.sv
// Round-robin scheduler sharing one AES-128 decrypt core among NREQ requesters.
// Reloads the key schedule only on key change and returns plaintext after a fixed core latency.
//
// state  | meaning
// IDLE   | waiting for a request; grant by round-robin from ptr
// KEYLD  | core and key expansion held in reset for the new key
// LAUNCH | start pulse to the core, latency counter loaded
// WAIT   | core running; plaintext captured when the counter reaches 1
// RESP   | plaintext offered to the granted requester until accepted
module aes_dec_sched #(
  parameter int NREQ     = 2,
  parameter int CORE_LAT = 11,
  parameter int IDXW     = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*128-1:0]  req_ct,
  input  logic [NREQ*128-1:0]  req_key,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [127:0]         rsp_pt,
  output logic                 core_start,
  output logic                 core_en,
  output logic                 core_rst_n,
  output logic                 core_ka_rst_n,
  output logic [127:0]         core_ct,
  output logic [127:0]         core_key,
  input  logic [127:0]         core_pt,
  output logic                 busy
);

  localparam int CNTW = $clog2(CORE_LAT + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYLD,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state, state_nx;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   gnt;
  logic [CNTW-1:0]   cnt;
  logic              key_vld;
  logic [127:0]      last_key;

  logic              gnt_found;
  logic [IDXW-1:0]   gnt_idx;
  logic [127:0]      sel_ct;
  logic [127:0]      sel_key;
  logic              key_hit;
  logic              rsp_hs;
  int                j;

  // Search from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_found && (i == j) && req_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = IDXW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_ct  = '0;
    sel_key = '0;
    rsp_hs  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDXW'(i)) begin
        sel_ct  = req_ct[128*i +: 128];
        sel_key = req_key[128*i +: 128];
      end
      if (gnt == IDXW'(i)) rsp_hs = rsp_ready[i];
    end
  end

  assign key_hit = key_vld && (sel_key == last_key);
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      S_IDLE: begin
        if (gnt_found) begin
          for (int i = 0; i < NREQ; i++) req_ready[i] = (gnt_idx == IDXW'(i));
          state_nx = key_hit ? S_LAUNCH : S_KEYLD;
        end
      end
      S_KEYLD:  state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (cnt == CNTW'(1)) state_nx = S_RESP;
      end
      S_RESP: begin
        for (int i = 0; i < NREQ; i++) rsp_valid[i] = (gnt == IDXW'(i));
        if (rsp_hs) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Core controls are registered from the next state so they line up with the state cycle
  // and sit at their reset values right after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      core_start    <= 1'b0;
      core_en       <= 1'b0;
      core_rst_n    <= 1'b0;
      core_ka_rst_n <= 1'b0;
    end else begin
      core_start    <= (state_nx == S_LAUNCH);
      core_en       <= (state_nx == S_LAUNCH) || (state_nx == S_WAIT);
      core_rst_n    <= (state_nx != S_KEYLD);
      core_ka_rst_n <= (state_nx != S_KEYLD);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr      <= '0;
      gnt      <= '0;
      cnt      <= '0;
      key_vld  <= 1'b0;
      last_key <= '0;
      core_ct  <= '0;
      core_key <= '0;
      rsp_pt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            gnt      <= gnt_idx;
            core_ct  <= sel_ct;
            core_key <= sel_key;
            ptr      <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          end
        end
        S_KEYLD: begin
          last_key <= core_key;
          key_vld  <= 1'b1;
        end
        S_LAUNCH: cnt <= CNTW'(CORE_LAT);
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNTW'(1)) rsp_pt <= core_pt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_sched.sv
// Directed bench for aes_dec_sched with a behavioural core that only decrypts correctly
// when its key schedule was reloaded and its output is sampled at exactly the right cycle.
module tb_aes_dec_sched;

  localparam int NREQ     = 2;
  localparam int CORE_LAT = 11;
  localparam int IDXW     = 3;

  localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] JUNK    = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  logic                 clk;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_ct;
  logic [NREQ*128-1:0]  req_key;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [127:0]         rsp_pt;
  logic                 core_start;
  logic                 core_en;
  logic                 core_rst_n;
  logic                 core_ka_rst_n;
  logic [127:0]         core_ct;
  logic [127:0]         core_key;
  logic [127:0]         core_pt;
  logic                 busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  aes_dec_sched #(.NREQ(NREQ), .CORE_LAT(CORE_LAT), .IDXW(IDXW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ct(req_ct), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pt(rsp_pt),
    .core_start(core_start), .core_en(core_en), .core_rst_n(core_rst_n),
    .core_ka_rst_n(core_ka_rst_n), .core_ct(core_ct), .core_key(core_key),
    .core_pt(core_pt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] fake_aes(input logic [127:0] ct, input logic [127:0] key);
    if (ct == AES_CT && key == AES_KEY) return AES_PT;
    return ct ^ key;
  endfunction

  // Core model: key latched only while key expansion is held in reset.
  logic [127:0] mkey = '0;
  logic [127:0] mct  = '0;
  int           mcnt = 0;
  always @(posedge clk) begin
    if (!core_ka_rst_n) mkey <= core_key;
    if (!core_rst_n) mcnt <= 0;
    else if (core_start) begin
      mcnt <= CORE_LAT;
      mct  <= core_ct;
    end else if (mcnt != 0) mcnt <= mcnt - 1;
  end
  assign core_pt = (mcnt == 1) ? fake_aes(mct, mkey) : JUNK;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) check("ready_rsp_exclusive", 128'(req_ready != 0 && rsp_valid != 0), 128'(0));
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      128'(busy),          128'(0));
    check({tag, "_req_ready"}, 128'(req_ready),     128'(0));
    check({tag, "_rsp_valid"}, 128'(rsp_valid),     128'(0));
    check({tag, "_start"},     128'(core_start),    128'(0));
    check({tag, "_en"},        128'(core_en),       128'(0));
    check({tag, "_rst_n"},     128'(core_rst_n),    128'(0));
    check({tag, "_ka_rst_n"},  128'(core_ka_rst_n), 128'(0));
    check({tag, "_core_ct"},   core_ct,             128'(0));
    check({tag, "_core_key"},  core_key,            128'(0));
    check({tag, "_rsp_pt"},    rsp_pt,              128'(0));
  endtask

  task automatic run_txn(input int r, input logic [127:0] ct, input logic [127:0] key,
                         input logic [127:0] pt, input bit reload, input int stall,
                         input logic [NREQ-1:0] also);
    int n;
    int lat;
    bit seen_kl;
    logic [127:0] held;
    @(posedge clk); #1;
    req_ct[r*128 +: 128]  = ct;
    req_key[r*128 +: 128] = key;
    req_valid[r] = 1'b1;
    req_valid    = req_valid | also;
    n = 0;
    @(negedge clk);
    while (!req_ready[r] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[r]) begin
      check("accept_timeout", 128'(req_ready), 128'(1) << r);
      req_valid = '0;
      return;
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    req_ct[r*128 +: 128]  = ~ct;
    req_key[r*128 +: 128] = ~key;
    lat = 0;
    seen_kl = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!core_ka_rst_n) seen_kl = 1'b1;
    end while (rsp_valid == 0 && lat < 60);
    check("latency", 128'(lat), reload ? 128'(CORE_LAT + 3) : 128'(CORE_LAT + 2));
    check("keyld_seen", 128'(seen_kl), 128'(reload));
    check("rsp_valid", 128'(rsp_valid), 128'(1) << r);
    check("rsp_pt", rsp_pt, pt);
    held = rsp_pt;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 128'(rsp_valid), 128'(1) << r);
      check("stall_pt", rsp_pt, held);
      check("stall_req_ready", 128'(req_ready), 128'(0));
    end
    @(posedge clk); #1 rsp_ready[r] = 1'b1;
    @(posedge clk); #1 rsp_ready[r] = 1'b0;
    if (also != 0) begin
      @(negedge clk);
      check("resume_ready", 128'(req_ready), 128'(also));
      req_valid = req_valid & ~also;
    end
  endtask

  typedef struct {
    int           r;
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    bit           reload;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int prev;
    bit seen;
    vecs[0] = '{0, AES_CT,       AES_KEY,      AES_PT,       1'b1};
    vecs[1] = '{1, AES_CT,       AES_KEY,      AES_PT,       1'b0};
    vecs[2] = '{0, {16{8'h11}},  {16{8'h22}},  {16{8'h33}},  1'b1};
    vecs[3] = '{1, {16{8'h44}},  {16{8'h88}},  {16{8'hcc}},  1'b1};
    vecs[4] = '{0, {16{8'h0f}},  {16{8'h88}},  {16{8'h87}},  1'b0};
    vecs[5] = '{1, 128'h0,       {16{8'hff}},  {16{8'hff}},  1'b1};

    reset_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_ct = '0;
    req_key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1 reset_n = 1'b1;

    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].r, vecs[v].ct, vecs[v].key, vecs[v].pt, vecs[v].reload, 0, '0);

    // Both requesters pending, same key, responses accepted immediately.
    @(posedge clk); #1;
    req_ct  = {{16{8'haa}}, 128'h0};
    req_key = {{16{8'hff}}, {16{8'hff}}};
    rsp_ready = '1;
    req_valid = '1;
    prev = 0;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      @(negedge clk);
      while (req_ready == 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("rr_grant", 128'(req_ready), (t % 2 == 0) ? 128'(1) : 128'(2));
      if (t > 0) check("rr_gap", 128'(cyc - prev), 128'(CORE_LAT + 3));
      prev = cyc;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (rsp_valid == 0 && n < 40);
      check("rr_pt", rsp_pt, (t % 2 == 0) ? {16{8'hff}} : {16{8'h55}});
    end
    req_valid = '0;
    @(posedge clk); #1 rsp_ready = '0;

    // Response stall with requester 1 waiting; it is granted right after the handshake.
    req_key[128 +: 128] = {16{8'h12}};
    run_txn(0, {16{8'h5a}}, {16{8'hff}}, {16{8'ha5}}, 1'b0, 20, 2'b10);

    // Reset in the middle of WAIT.
    @(posedge clk); #1;
    req_ct[0 +: 128]  = 128'h0;
    req_key[0 +: 128] = {16{8'h77}};
    req_valid[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_in_wait", 128'(busy), 128'(1));
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    seen = 1'b0;
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      if (rsp_valid != 0) seen = 1'b1;
    end
    check("midrst_no_rsp", 128'(seen), 128'(0));
    req_key[128 +: 128] = {16{8'h77}};
    run_txn(0, 128'h0, {16{8'h77}}, {16{8'h77}}, 1'b1, 0, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_dec_sched.md
Name: aes_dec_sched

Overview:
Round-robin scheduler that shares one AES-128 decrypt core among NREQ requesters. Each requester has its own valid/ready ciphertext+key request channel and valid/ready plaintext response channel. The scheduler accepts one request at a time and drives the core's start/enable/reset controls. It reloads the key schedule only when the key changes, waits a fixed core latency, then captures the plaintext and returns it to the granted requester.

Parameters:
NREQ, 2, number of requesters (2..8)
CORE_LAT, 11, cycles from core_start sample to valid core_pt (inclusive of start cycle's successor)
IDXW, 3, width of grant index (ceil(log2(NREQ)), min 1)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester request accept (one-hot or zero)
req_ct  in  NREQ*128  ciphertexts, requester i at [128*i+127:128*i]
req_key  in  NREQ*128  keys, same packing
rsp_valid  out  NREQ  per-requester response valid (one-hot or zero)
rsp_ready  in  NREQ  per-requester response accept
rsp_pt  out  128  plaintext, shared bus, meaningful only with rsp_valid
core_start  out  1  one-cycle start pulse to decrypt core
core_en  out  1  key-expansion enable
core_rst_n  out  1  core FSM reset, active low
core_ka_rst_n  out  1  key-expansion reset, active low
core_ct  out  128  registered ciphertext to core
core_key  out  128  registered key to core
core_pt  in  128  core plaintext
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; rr pointer=0; key_vld=0; last_key=0; core_ct/core_key/rsp_pt=0; core_start=0, core_en=0, core_rst_n=0, core_ka_rst_n=0. A mid-operation reset abandons the transaction with no response.
- States: IDLE, KEYLD, LAUNCH, WAIT, RESP.
- IDLE: core_rst_n=1, core_ka_rst_n=1. Grant g is the first i with req_valid[i]=1, searching from ptr upward with wrap mod NREQ. req_ready[g]=1 (combinational), all other req_ready bits 0. No request pending -> req_ready=0 and state stays IDLE.
  - On accept: latch g, core_ct<=req_ct[g], core_key<=req_key[g]; ptr<=(g+1) mod NREQ.
  - If key_vld=0 or req_key[g]!=last_key -> KEYLD; otherwise -> LAUNCH.
- KEYLD (1 cycle): core_rst_n=0, core_ka_rst_n=0, core_en=0. Update last_key<=core_key, key_vld<=1. Next state LAUNCH.
- LAUNCH (1 cycle): core_rst_n=1, core_ka_rst_n=1, core_start=1, core_en=1. Load cnt<=CORE_LAT. Next state WAIT.
- WAIT: core_en=1, core_start=0, cnt decrements each cycle. On the cycle with cnt==1: rsp_pt<=core_pt, then RESP.
- RESP: rsp_valid[g]=1, rsp_pt held stable, core_en=0. On rsp_valid&rsp_ready[g] -> IDLE. No timeout; stall holds indefinitely. New requests are not accepted until IDLE.
- Latency (accept cycle = 0): rsp_valid rises at cycle CORE_LAT+2 on key reuse, CORE_LAT+3 on key reload. Back-to-back same-key throughput: one block per CORE_LAT+3 cycles with rsp_ready tied high.
- Simultaneous requests: strict round-robin, so no requester is skipped more than NREQ-1 times. A requester may drop req_valid before being granted; it is then not granted.
- req_ct/req_key are sampled only at accept, so later changes on the inputs are ignored.
- rsp_valid and req_ready are never both nonzero in the same cycle.

Test Plan:
- Single request, requester 0, ct=69c4e0d86a7b0430d8cdb78070b4c55a, key=000102030405060708090a0b0c0d0e0f -> one KEYLD cycle; rsp_valid[0] at cycle CORE_LAT+3 with rsp_pt=00112233445566778899aabbccddeeff.
- Same key, second block from requester 1 -> no KEYLD (core_ka_rst_n stays 1); rsp_valid[1] at cycle CORE_LAT+2 with correct plaintext.
- NREQ=2, both req_valid held high, four transactions -> grant order 0,1,0,1; ptr wraps at 1->0.
- Different keys alternating between requesters -> KEYLD on every transaction; all plaintexts match reference model.
- rsp_ready held low 20 cycles in RESP -> rsp_valid and rsp_pt stable, req_ready=0 throughout; accept resumes one cycle after handshake.
- reset_n pulsed low during WAIT -> next cycle IDLE, all outputs at reset values, no rsp_valid; next request with the previous key still takes KEYLD (key_vld cleared).
